// File: rtl/thermal_pkg.sv
`default_nettype none
// ============================================================================
// Package     : thermal_pkg
// Description : Shared types for the thermal frame pipeline: frame-statistics
//               scanner state and register bundle, plus normalizer types.
// Revision    : 1.0 - initial release
// ============================================================================
package thermal_pkg;

  // Storage width of the scanner's running min/max. Raw pixels (DATAW bits)
  // are sign-extended into this width, so DATAW must be below this value.
  localparam int SCAN_DATAW_MAX = 32;
  // Storage width of the scanner's address counter (MAX_ADDR must fit).
  localparam int SCAN_ADDRW_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  // Registered scanner state. An all-zero value is the idle/cleared state.
  typedef struct packed {
    scan_state_e               state;
    logic [SCAN_ADDRW_MAX-1:0] addr;
    logic                      first;
    logic [SCAN_DATAW_MAX-1:0] min_v;
    logic [SCAN_DATAW_MAX-1:0] max_v;
  } scan_regs_t;

  // Normalizer types: the scanner's o_min/o_range feed these on o_done.
  localparam int NORM_OUTW = 8;

  typedef enum logic [1:0] {
    NORM_IDLE = 2'd0,
    NORM_RUN  = 2'd1,
    NORM_DONE = 2'd2
  } norm_state_e;

  typedef struct packed {
    logic [SCAN_DATAW_MAX-1:0] offset;
    logic [SCAN_DATAW_MAX-1:0] span;
  } norm_cfg_t;

  // Signed less-than on sign-extended storage words.
  function automatic logic signed_lt(input logic [SCAN_DATAW_MAX-1:0] a,
                                     input logic [SCAN_DATAW_MAX-1:0] b);
    return $signed(a) < $signed(b);
  endfunction

endpackage : thermal_pkg
`default_nettype wire

// File: rtl/frame_stats_scanner.sv
`default_nettype none
// ============================================================================
// Module      : frame_stats_scanner
// Description : Reads one frame (addresses 0..MAX_ADDR) from a fixed-latency
//               memory and reports the signed minimum and the max-min range,
//               with a one-cycle o_done pulse when the statistics are valid.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_stats_scanner
  import thermal_pkg::*;
#(
  parameter int  DATAW      = 16,
  parameter int  MAX_ADDR   = 63,
  parameter int  RD_LATENCY = 1,
  localparam int ADDRW      = $clog2(MAX_ADDR + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  output logic                    o_rd_valid,
  output logic [ADDRW-1:0]        o_rd_addr,
  input  logic signed [DATAW-1:0] i_rd_data,
  output logic                    o_done,
  output logic signed [DATAW-1:0] o_min,
  output logic [DATAW-1:0]        o_range,
  output logic                    o_busy,
  output logic                    o_debug_busy_req
);

  localparam logic [SCAN_ADDRW_MAX-1:0] c_last_addr = SCAN_ADDRW_MAX'(MAX_ADDR);
  // Valid-pipe pattern meaning "only the final sample is still in flight".
  localparam logic [RD_LATENCY-1:0] c_last_pipe = RD_LATENCY'(1) << (RD_LATENCY - 1);

  scan_regs_t              r_scan_q;
  logic                    r_rd_valid_q;
  logic [RD_LATENCY-1:0]   r_vpipe_q;
  logic                    r_done_q;
  logic signed [DATAW-1:0] r_min_q;
  logic [DATAW-1:0]        r_range_q;
  logic                    r_busy_req_q;

  logic [RD_LATENCY-1:0]     w_vpipe_d;
  logic                      w_sample_vld;
  logic [SCAN_DATAW_MAX-1:0] w_sample;
  logic [SCAN_DATAW_MAX-1:0] w_min_d;
  logic [SCAN_DATAW_MAX-1:0] w_max_d;
  logic [DATAW:0]            w_range_d;
  logic                      w_unused_range_msb;
  logic                      w_last_sample;

  // The valid pipe tracks which cycles carry returning read data.
  generate
    if (RD_LATENCY == 1) begin : g_vpipe_single
      assign w_vpipe_d = r_rd_valid_q;
    end else begin : g_vpipe_shift
      assign w_vpipe_d = {r_vpipe_q[RD_LATENCY-2:0], r_rd_valid_q};
    end
  endgenerate

  assign w_sample_vld  = r_vpipe_q[RD_LATENCY-1];
  assign w_sample      = {{(SCAN_DATAW_MAX-DATAW){i_rd_data[DATAW-1]}}, i_rd_data};
  assign w_last_sample = (r_scan_q.state == ST_DRAIN) && (r_vpipe_q == c_last_pipe);

  // Fold the returning sample into the running min/max (first sample seeds both).
  always_comb begin
    w_min_d = r_scan_q.min_v;
    w_max_d = r_scan_q.max_v;
    if (w_sample_vld) begin
      if (r_scan_q.first) begin
        w_min_d = w_sample;
        w_max_d = w_sample;
      end else begin
        if (signed_lt(w_sample, r_scan_q.min_v)) w_min_d = w_sample;
        if (signed_lt(r_scan_q.max_v, w_sample)) w_max_d = w_sample;
      end
    end
  end

  // Range needs DATAW+1 bits for the subtraction, but max-min of two DATAW-bit
  // signed values always fits in DATAW unsigned bits, so the MSB is dropped.
  assign w_range_d = {w_max_d[DATAW-1], w_max_d[DATAW-1:0]}
                   - {w_min_d[DATAW-1], w_min_d[DATAW-1:0]};
  assign w_unused_range_msb = w_range_d[DATAW];

  // Scan controller: address generation, drain tracking and result capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scan_q     <= '0;
      r_rd_valid_q <= 1'b0;
      r_vpipe_q    <= '0;
      r_done_q     <= 1'b0;
      r_min_q      <= '0;
      r_range_q    <= '0;
      r_busy_req_q <= 1'b0;
    end else begin
      r_vpipe_q      <= w_vpipe_d;
      r_done_q       <= 1'b0;
      r_scan_q.min_v <= w_min_d;
      r_scan_q.max_v <= w_max_d;
      if (w_sample_vld) r_scan_q.first <= 1'b0;
      if (i_start && (r_scan_q.state != ST_IDLE)) r_busy_req_q <= 1'b1;

      case (r_scan_q.state)
        ST_IDLE: begin
          if (i_start) begin
            r_scan_q.state <= ST_SCAN;
            r_scan_q.addr  <= '0;
            r_scan_q.first <= 1'b1;
            r_rd_valid_q   <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (r_scan_q.addr == c_last_addr) begin
            r_rd_valid_q   <= 1'b0;
            r_scan_q.state <= ST_DRAIN;
          end else begin
            r_scan_q.addr <= r_scan_q.addr + SCAN_ADDRW_MAX'(1);
          end
        end
        ST_DRAIN: begin
          // Capture on the edge that absorbs the final sample so that the
          // statistics and o_done appear together in the DONE cycle.
          if (w_last_sample) begin
            r_scan_q.state <= ST_DONE;
            r_done_q       <= 1'b1;
            r_min_q        <= w_min_d[DATAW-1:0];
            r_range_q      <= w_range_d[DATAW-1:0];
          end
        end
        ST_DONE: begin
          r_scan_q.state <= ST_IDLE;
        end
        default: begin
          r_scan_q     <= '0;
          r_rd_valid_q <= 1'b0;
          r_vpipe_q    <= '0;
          r_done_q     <= 1'b0;
          r_min_q      <= '0;
          r_range_q    <= '0;
          r_busy_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_rd_valid       = r_rd_valid_q;
  assign o_rd_addr        = r_scan_q.addr[ADDRW-1:0];
  assign o_done           = r_done_q;
  assign o_min            = r_min_q;
  assign o_range          = r_range_q;
  assign o_busy           = (r_scan_q.state != ST_IDLE);
  assign o_debug_busy_req = r_busy_req_q;

endmodule : frame_stats_scanner
`default_nettype wire

// File: tb/tb_frame_stats_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_stats_scanner
// Description : Bench for frame_stats_scanner. Two instances (read latency 1
//               and 3) scan the same frame memory; a frame-level model
//               predicts timing and statistics for both.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_stats_scanner;

  localparam int N = 64;

  logic clk = 1'b0;
  logic rst;
  logic start;

  logic                rd_valid [2];
  logic [5:0]          rd_addr  [2];
  logic signed [15:0]  rd_data  [2];
  logic                done     [2];
  logic signed [15:0]  omin     [2];
  logic [15:0]         orng     [2];
  logic                busy     [2];
  logic                dbg      [2];

  logic signed [15:0]  frame [N];
  logic signed [15:0]  dq [2][4];

  int n_vec = 0;
  int n_err = 0;
  int e = 0;
  bit chk_en = 1'b0;

  // model state per instance
  int                 ks       [2] = '{-1000, -1000};
  logic signed [15:0] pend_min [2];
  logic [15:0]        pend_rng [2];
  logic signed [15:0] m_min    [2] = '{16'sd0, 16'sd0};
  logic [15:0]        m_rng    [2] = '{16'd0, 16'd0};
  logic               m_dbg    [2] = '{1'b0, 1'b0};
  int                 done_cnt [2] = '{0, 0};
  int                 done_edge[2] = '{0, 0};

  always #5 clk = ~clk;

  frame_stats_scanner #(.DATAW(16), .MAX_ADDR(63), .RD_LATENCY(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_rd_valid(rd_valid[0]), .o_rd_addr(rd_addr[0]), .i_rd_data(rd_data[0]),
    .o_done(done[0]), .o_min(omin[0]), .o_range(orng[0]),
    .o_busy(busy[0]), .o_debug_busy_req(dbg[0])
  );

  frame_stats_scanner #(.DATAW(16), .MAX_ADDR(63), .RD_LATENCY(3)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_rd_valid(rd_valid[1]), .o_rd_addr(rd_addr[1]), .i_rd_data(rd_data[1]),
    .o_done(done[1]), .o_min(omin[1]), .o_range(orng[1]),
    .o_busy(busy[1]), .o_debug_busy_req(dbg[1])
  );

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic frame_stats(output logic signed [15:0] mn, output logic [15:0] rg);
    int lo, hi;
    lo = frame[0];
    hi = frame[0];
    for (int a = 1; a < N; a++) begin
      if (frame[a] < lo) lo = frame[a];
      if (frame[a] > hi) hi = frame[a];
    end
    mn = 16'(lo);
    rg = 16'(hi - lo);
  endtask

  task automatic chk(input string nm, input int idx, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (edge %0d)", nm, idx, act, exp, e);
    end
  endtask

  // Memory with fixed read latency; non-requested cycles return junk.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 3; j > 0; j--) dq[i][j] <= dq[i][j-1];
      dq[i][0] <= rd_valid[i] ? frame[rd_addr[i]] : 16'($urandom);
    end
  end
  assign rd_data[0] = dq[0][0];
  assign rd_data[1] = dq[1][2];

  // Frame-level model: a start accepted at edge ks reads for N cycles and
  // reports after ks+N+L; results are the min/range of the frame at ks.
  always @(posedge clk) begin
    e = e + 1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ks[i] = -1000;
        m_min[i] = 16'sd0;
        m_rng[i] = 16'd0;
        m_dbg[i] = 1'b0;
      end else begin
        if (e == ks[i] + N + lat_of(i)) begin
          m_min[i] = pend_min[i];
          m_rng[i] = pend_rng[i];
        end
        if (start) begin
          if (e >= ks[i] + 1 && e <= ks[i] + N + lat_of(i) + 1) m_dbg[i] = 1'b1;
          else begin
            ks[i] = e;
            frame_stats(pend_min[i], pend_rng[i]);
          end
        end
      end
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        bit xv;
        xv = (e >= ks[i]) && (e <= ks[i] + N - 1);
        chk("rd_valid", i, rd_valid[i], xv);
        if (xv) chk("rd_addr", i, rd_addr[i], e - ks[i]);
        chk("done", i, done[i], (e == ks[i] + N + lat_of(i)));
        chk("busy", i, busy[i], (e >= ks[i]) && (e <= ks[i] + N + lat_of(i)));
        chk("min", i, omin[i], m_min[i]);
        chk("range", i, orng[i], m_rng[i]);
        chk("dbg", i, dbg[i], m_dbg[i]);
        if (done[i]) begin
          done_cnt[i]++;
          done_edge[i] = e;
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy[0] || busy[1]) && n < 1000);
    chk("idle_timeout", 0, busy[0] || busy[1], 0);
  endtask

  task automatic chk_lit(input string nm, input int i, input longint mn, input longint rg);
    chk({nm, "_min"}, i, omin[i], mn);
    chk({nm, "_range"}, i, orng[i], rg);
  endtask

  initial begin
    int c0 [2];
    int n;
    rst = 1'b1;
    start = 1'b0;
    for (int a = 0; a < N; a++) frame[a] = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk_lit("reset", i, 0, 0);
      chk("reset_busy", i, busy[i], 0);
      chk("reset_dbg", i, dbg[i], 0);
    end

    // ramp: address-50
    for (int a = 0; a < N; a++) frame[a] = 16'(a - 50);
    pulse_start();
    wait_idle();
    chk_lit("ramp", 0, -50, 63);
    chk_lit("ramp", 1, -50, 63);
    chk("ramp_latency", 0, done_edge[0] - ks[0], 65);
    chk("ramp_latency", 1, done_edge[1] - ks[1], 67);

    // constant frame
    for (int a = 0; a < N; a++) frame[a] = 16'sd1234;
    pulse_start();
    wait_idle();
    chk_lit("const", 0, 1234, 0);
    chk_lit("const", 1, 1234, 0);

    // extremes
    for (int a = 0; a < N; a++) frame[a] = '0;
    frame[0] = 16'sh8000;
    frame[63] = 16'sh7fff;
    pulse_start();
    wait_idle();
    chk_lit("extreme", 0, -32768, 65535);
    chk_lit("extreme", 1, -32768, 65535);

    // start while busy
    for (int i = 0; i < 2; i++) c0[i] = done_cnt[i];
    for (int a = 0; a < N; a++) frame[a] = 16'(a * 5 - 7);
    pulse_start();
    repeat (8) @(posedge clk);
    pulse_start();
    wait_idle();
    repeat (5) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("busy_req_one_done", i, done_cnt[i] - c0[i], 1);
      chk("busy_req_flag", i, dbg[i], 1);
      chk_lit("busy_req", i, -7, 315);
    end
    pulse_reset();
    @(negedge clk);
    chk("dbg_cleared", 0, dbg[0], 0);

    // reset mid-scan, then a fresh scan
    for (int i = 0; i < 2; i++) c0[i] = done_cnt[i];
    pulse_start();
    repeat (18) @(posedge clk);
    pulse_reset();
    repeat (80) @(negedge clk);
    for (int i = 0; i < 2; i++) chk("abort_no_done", i, done_cnt[i] - c0[i], 0);
    for (int a = 0; a < N; a++) frame[a] = 16'(a * 3 - 100);
    pulse_start();
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      chk("abort_then_scan_done", i, done_cnt[i] - c0[i], 1);
      chk_lit("abort_then_scan", i, -100, 189);
    end

    // back-to-back at latency 3
    for (int a = 0; a < N; a++) frame[a] = 16'sd7;
    frame[5] = -16'sd9;
    pulse_start();
    n = 0;
    while (!done[1] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_done", 1, done[1], 1);
    chk_lit("b2b_first", 1, -9, 16);
    @(posedge clk);
    #1;
    for (int a = 0; a < N; a++) frame[a] = 16'(a * 2);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    chk_lit("b2b_second", 1, 0, 126);
    chk("b2b_no_busy_req", 1, dbg[1], 0);

    // randomized frames and start timing
    for (int t = 0; t < 20; t++) begin
      for (int a = 0; a < N; a++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) frame[a] = 16'sh8000;
        else if (r == 1) frame[a] = 16'sh7fff;
        else frame[a] = 16'($urandom);
      end
      if (t % 4 == 3) for (int a = 0; a < N; a++) frame[a] = 16'(100 + $urandom_range(0, 20));
      repeat ($urandom_range(0, 4)) @(posedge clk);
      pulse_start();
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 60)) @(posedge clk);
        pulse_start();
      end
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_frame_stats_scanner
`default_nettype wire
